// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic valid/ready pipeline stage buffer.
// Holds up to DEPTH entries of a DATA_W-wide payload in a circular store.
// in_ready is decoded from the registered occupancy only, so there is no
// combinational path from out_ready to in_ready. Nothing from the input side
// reaches the outputs in the same cycle. When empty, out_data is forced to
// zero, so an empty stage looks like a nop bubble downstream. flush empties
// the buffer at a clock edge and wins over any push or pop in that cycle.
// Optional feature: define PIPE_STAGE_DBG_PC_EN to carry a 32-bit PC tag
// (in_pc/out_pc) alongside every entry.
module pipe_stage_buf #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef PIPE_STAGE_DBG_PC_EN
    input  logic [31:0]       in_pc,
    output logic [31:0]       out_pc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
`ifdef PIPE_STAGE_DBG_PC_EN
    logic [31:0]       pc_mem_r [DEPTH];
`endif
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic              empty_s;

    // Advance a circular pointer; DEPTH need not be a power of two, so wrap
    // by explicit compare against the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] res;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            res = {PTR_W{1'b0}};
        end else begin
            res = ptr + PTR_W'(1);
        end
        return res;
    endfunction

    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign in_ready  = (count_r != CNT_W'(DEPTH));
    assign out_valid = !empty_s;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign count     = count_r;

    // Head payload, masked to zero while empty so stale storage never leaks.
    always_comb begin
        out_data = {DATA_W{1'b0}};
        if (!empty_s) begin
            out_data = mem_r[rd_ptr_r];
        end else begin
            out_data = {DATA_W{1'b0}};
        end
    end

`ifdef PIPE_STAGE_DBG_PC_EN
    // Head PC tag, masked the same way as the payload.
    always_comb begin
        out_pc = 32'h0000_0000;
        if (!empty_s) begin
            out_pc = pc_mem_r[rd_ptr_r];
        end else begin
            out_pc = 32'h0000_0000;
        end
    end
`endif

    // Next pointer/occupancy values; flush overrides push and pop.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Entry storage; written on an accepted push unless the cycle is flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
`ifdef PIPE_STAGE_DBG_PC_EN
                pc_mem_r[i] <= 32'h0000_0000;
`endif
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= in_data;
`ifdef PIPE_STAGE_DBG_PC_EN
            pc_mem_r[wr_ptr_r] <= in_pc;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: DUT a (DEPTH=2) covers reset,
// streaming, backpressure, flush and PC tagging; DUT b (DEPTH=3) covers
// non-power-of-two wrap under irregular out_ready.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT a signals
    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_in_data = 32'h0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_count;
    logic [31:0] a_in_pc = 32'h0;
    logic [31:0] a_out_pc;

    // DUT b signals
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_data = 32'h0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;
    logic [31:0] b_in_pc = 32'h0;
    logic [31:0] b_out_pc;

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
`ifdef PIPE_STAGE_DBG_PC_EN
        .in_pc(a_in_pc), .out_pc(a_out_pc),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
`ifdef PIPE_STAGE_DBG_PC_EN
        .in_pc(b_in_pc), .out_pc(b_out_pc),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

`ifndef PIPE_STAGE_DBG_PC_EN
    assign a_out_pc = 32'h0;
    assign b_out_pc = 32'h0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] aq[$];
    logic [63:0] bq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream protocol: payload stays stable while stalled.
    a_hold: assert property (@(posedge clk) disable iff (!rst)
        (a_in_valid && !a_in_ready && !a_flush) |=> (!a_in_valid || $stable(a_in_data)));
    b_hold: assert property (@(posedge clk) disable iff (!rst)
        (b_in_valid && !b_in_ready) |=> (!b_in_valid || $stable(b_in_data)));

    // Monitor a: record accepted pushes, compare every pop, check bubble mask.
    always @(negedge clk) begin
        if (rst) begin
            if (!a_out_valid) begin
                check("a_bubble_data", {32'h0, a_out_data}, 64'h0);
                check("a_bubble_pc", {32'h0, a_out_pc}, 64'h0);
            end
            if (a_flush) begin
                aq.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (aq.size() == 0) begin
                        check("a_unexpected_out", {32'h0, a_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("a_out", {a_out_pc, a_out_data}, aq.pop_front());
                    end
                end
                if (a_in_valid && a_in_ready) begin
`ifdef PIPE_STAGE_DBG_PC_EN
                    aq.push_back({a_in_pc, a_in_data});
`else
                    aq.push_back({32'h0, a_in_data});
`endif
                end
            end
        end
    end

    // Monitor b: same scoreboard for the DEPTH=3 instance.
    always @(negedge clk) begin
        if (rst) begin
            if (b_out_valid && b_out_ready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected_out", {32'h0, b_out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("b_out", {b_out_pc, b_out_data}, bq.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) begin
`ifdef PIPE_STAGE_DBG_PC_EN
                bq.push_back({b_in_pc, b_in_data});
`else
                bq.push_back({32'h0, b_in_data});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a(input string name);
        int k;
        k = 0;
        while (a_count != 2'd0 && k < 20) begin
            step();
            k++;
        end
        check(name, {62'h0, a_count}, 64'h0);
    endtask

    initial begin
        logic [15:0] rdy_pat;
        int idx;
        int cyc;
        logic acc;
        rdy_pat = 16'b1011_0010_1101_0110;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, a_out_valid}, 64'h0);
        check("rst_count", {62'h0, a_count}, 64'h0);
        rst = 1'b1;
        step();
        check("idle_out_valid", {63'h0, a_out_valid}, 64'h0);
        check("idle_out_data", {32'h0, a_out_data}, 64'h0);
        check("idle_count", {62'h0, a_count}, 64'h0);
        check("idle_in_ready", {63'h0, a_in_ready}, 64'h1);

        // Streaming 1..8, one transfer per cycle, count steady at 1.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(i);
            step();
            check("stream_count", {62'h0, a_count}, 64'h1);
            check("stream_head", {32'h0, a_out_data}, 64'(i));
        end
        a_in_valid = 1'b0;
        step();
        check("stream_drained", {62'h0, a_count}, 64'h0);

        // Backpressure fill: A, B accepted; C stalls.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hA; step();
        a_in_data = 32'hB; step();
        check("bp_count2", {62'h0, a_count}, 64'h2);
        check("bp_in_ready", {63'h0, a_in_ready}, 64'h0);
        a_in_data = 32'hC; step();
        check("bp_still_full", {62'h0, a_count}, 64'h2);
        check("bp_head", {32'h0, a_out_data}, 64'hA);
        a_out_ready = 1'b1; step();
        check("bp_pop_no_push", {62'h0, a_count}, 64'h1);
        step();
        a_in_valid = 1'b0;
        drain_a("bp_drain");

        // Flush priority over simultaneous push and pop.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h5; step();
        a_in_data = 32'h6; step();
        check("fl_count2", {62'h0, a_count}, 64'h2);
        a_in_data = 32'h7; a_out_ready = 1'b1; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_count", {62'h0, a_count}, 64'h0);
        check("fl_out_valid", {63'h0, a_out_valid}, 64'h0);
        check("fl_out_data", {32'h0, a_out_data}, 64'h0);
        check("fl_in_ready", {63'h0, a_in_ready}, 64'h1);
        repeat (3) step();
        check("fl_no_0x7", {63'h0, a_out_valid}, 64'h0);

        // Tagged pairs under backpressure.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hD0; a_in_pc = 32'h400; step();
        a_in_data = 32'hD1; a_in_pc = 32'h404; step();
        a_in_valid = 1'b0;
        check("pc_head_data", {32'h0, a_out_data}, 64'hD0);
`ifdef PIPE_STAGE_DBG_PC_EN
        check("pc_head_tag", {32'h0, a_out_pc}, 64'h400);
`endif
        a_out_ready = 1'b1; step();
        check("pc_second_data", {32'h0, a_out_data}, 64'hD1);
`ifdef PIPE_STAGE_DBG_PC_EN
        check("pc_second_tag", {32'h0, a_out_pc}, 64'h404);
`endif
        drain_a("pc_drain");

        // DEPTH=3 wrap: 0x10..0x19 with irregular out_ready.
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 200) begin
            b_in_valid  = 1'b1;
            b_in_data   = 32'h10 + 32'(idx);
            b_in_pc     = 32'h1000 + 32'(idx * 4);
            b_out_ready = rdy_pat[cyc % 16];
            acc = b_in_ready;
            step();
            if (acc) idx++;
            if (b_count > 2'd3) check("b_count_max", {62'h0, b_count}, 64'h3);
            cyc++;
        end
        check("b_all_pushed", 64'(idx), 64'd10);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        cyc = 0;
        while (b_count != 2'd0 && cyc < 20) begin
            step();
            cyc++;
        end
        check("b_drain", {62'h0, b_count}, 64'h0);

        step();
        check("a_queue_empty", 64'(aq.size()), 64'h0);
        check("b_queue_empty", 64'(bq.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
